dmem_responder: RTL and testbench

//  Data-memory responder for the rv32 pipeline's load/store port: accepts one

---
 rtl/dmem_responder_pkg.sv | 22 ++
 rtl/dmem_responder_lane_align.sv | 57 +++++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store size codes
// and a helper that classifies which func3 values name a real access size.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_t;

    function automatic logic size_legal(input logic [2:0] func3);
        logic legal;
        case (func3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for one 32-bit word: store byte enables and replicated
// write data, load extraction with sign/zero extension, and alignment check.
module mem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = rword >> {addr, 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = wdata;
        load_data  = 32'd0;
        misaligned = 1'b0;
        case (size)
            MEM_B: begin
                byte_en    = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_BU: begin
                byte_en    = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {24'd0, shifted[7:0]};
            end
            MEM_H: begin
                byte_en    = 4'b0011 << addr;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr[0];
            end
            MEM_HU: begin
                byte_en    = 4'b0011 << addr;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {16'd0, shifted[15:0]};
                misaligned = addr[0];
            end
            MEM_W: begin
                byte_en    = 4'b1111;
                load_data  = rword;
                misaligned = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a load/store, waits
// LATENCY cycles, performs it on an internal word array and holds the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_LIM = DEPTH_WORDS;
    localparam logic [3:0]  LAT_LAST  = 4'(LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [2:0]  func3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rword_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        access;
    logic        access_err;
    logic [3:0]  byte_en;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] merged;

    assign accept = req_valid && (state_reg == ST_IDLE);
    assign access = (state_reg == ST_WAIT) && (cnt_reg == LAT_LAST);

    mem_lane_align u_align (
        .size       (func3_reg),
        .addr       (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .rword      (rword_reg),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign access_err = ({2'b00, addr_reg[31:2]} >= DEPTH_LIM)
                      || !size_legal(func3_reg)
                      || (we_reg && func3_reg[2])
                      || misaligned;

    // Stores are read-modify-write on the word fetched at accept time.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[8*gi +: 8] = byte_en[gi] ? lane_wdata[8*gi +: 8] : rword_reg[8*gi +: 8];
    end

    // Array read is registered while idle so the word is ready by the access cycle.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE) begin
            rword_reg <= mem[req_addr[IDX_W+1:2]];
        end
        if (!rst && access && we_reg && !access_err) begin
            mem[addr_reg[IDX_W+1:2]] <= merged;
        end
    end

    // Every request passes through WAIT (one cycle even at LATENCY=0), which
    // keeps the response exactly LATENCY+1 cycles after the accepting edge.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_WAIT;
                    cnt_next   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (access) begin
                    state_next = ST_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            func3_reg <= 3'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                func3_reg <= req_func3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (access) begin
                err_reg   <= access_err;
                rdata_reg <= (access_err || we_reg) ? 32'd0 : load_data;
            end
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-level
// reference memory kept in the bench.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [0:4*DEPTH-1];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, size/sign rules applied arithmetically.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output bit [31:0] rd, output bit err);
        int sz;
        bit sgn;
        bit legal;
        legal = 1'b1;
        sgn   = 1'b0;
        sz    = 1;
        case (f3)
            3'd0: begin sz = 1; sgn = 1'b1; end
            3'd1: begin sz = 2; sgn = 1'b1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: legal = 1'b0;
        endcase
        err = !legal || ((a / 4) >= DEPTH) || ((a % sz) != 0) || (we && f3 >= 3'd4);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = sz - 1; i >= 0; i--) rd = (rd << 8) | 32'(ref_mem[a + i]);
                if (sgn && rd[8*sz-1]) rd = rd | ~((32'd1 << (8*sz)) - 32'd1);
            end
        end
    endtask

    task automatic issue(input string tag, input bit we, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge.
    task automatic finish_rsp(input string tag, input bit [31:0] exp_rd, input bit exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        $display("%s: rdata=%h err=%0b (expected %h/%0b) after %0d cycles",
                 tag, rsp_rdata, rsp_err, exp_rd, exp_err, n);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input bit we, input bit [2:0] f3,
                        input bit [31:0] a, input bit [31:0] wd,
                        input bit use_exp, input bit [31:0] exp_rd, input bit exp_err);
        bit [31:0] m_rd;
        bit        m_err;
        model(we, f3, a, wd, m_rd, m_err);
        if (use_exp) begin
            m_rd  = exp_rd;
            m_err = exp_err;
        end
        issue(tag, we, f3, a, wd);
        finish_rsp(tag, m_rd, m_err);
    endtask

    initial begin
        bit [31:0] exp_rd;
        bit        exp_err;
        bit [2:0]  f3_tab [10];
        int        n;

        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);

        for (int i = 0; i < 16; i++) begin
            xact($sformatf("init_sw_%0d", i), 1'b1, 3'd2, 32'(4*i), $urandom, 1'b0, 32'd0, 1'b0);
        end

        xact("sw_deadbeef", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        xact("lw_10",       1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        xact("lb_13",       1'b0, 3'd0, 32'h13, 32'd0, 1'b1, 32'hFFFFFFDE, 1'b0);
        xact("lbu_13",      1'b0, 3'd4, 32'h13, 32'd0, 1'b1, 32'h000000DE, 1'b0);
        xact("lh_10",       1'b0, 3'd1, 32'h10, 32'd0, 1'b1, 32'hFFFFBEEF, 1'b0);
        xact("lhu_12",      1'b0, 3'd5, 32'h12, 32'd0, 1'b1, 32'h0000DEAD, 1'b0);
        xact("sb_11",       1'b1, 3'd0, 32'h11, 32'hFFFFFF12, 1'b1, 32'd0, 1'b0);
        xact("lw_after_sb", 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'hDEAD12EF, 1'b0);
        xact("sh_12",       1'b1, 3'd1, 32'h12, 32'hAAAA5566, 1'b1, 32'd0, 1'b0);
        xact("lw_after_sh", 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h556612EF, 1'b0);

        xact("err_lw_11",   1'b0, 3'd2, 32'h11, 32'd0, 1'b1, 32'd0, 1'b1);
        xact("err_lh_13",   1'b0, 3'd1, 32'h13, 32'd0, 1'b1, 32'd0, 1'b1);
        xact("err_sw_12",   1'b1, 3'd2, 32'h12, 32'h11111111, 1'b1, 32'd0, 1'b1);
        xact("err_func3_3", 1'b0, 3'd3, 32'h10, 32'd0, 1'b1, 32'd0, 1'b1);
        xact("err_sbu",     1'b1, 3'd4, 32'h10, 32'h000000AA, 1'b1, 32'd0, 1'b1);
        xact("err_oob",     1'b0, 3'd2, 32'(4*DEPTH), 32'd0, 1'b1, 32'd0, 1'b1);
        xact("lw_10_kept",  1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h556612EF, 1'b0);
        xact("lw_last",     1'b0, 3'd2, 32'(4*DEPTH-4), 32'd0, 1'b0, 32'd0, 1'b0);

        // Response held with rsp_ready low while another request is waiting.
        model(1'b0, 3'd2, 32'h10, 32'd0, exp_rd, exp_err);
        issue("hold", 1'b0, 3'd2, 32'h10, 32'd0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_latency", 32'(n), 32'(LAT + 1));
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h14; req_wdata = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("hold_rdata_%0d", i), rsp_rdata, exp_rd);
            check($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'd0);
        end
        $display("hold: rdata=%h held 5 cycles", rsp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("hold_idle_ready", 32'(req_ready), 32'd1);
        check("hold_idle_valid", 32'(rsp_valid), 32'd0);
        model(1'b0, 3'd2, 32'h14, 32'd0, exp_rd, exp_err);
        @(posedge clk);
        #1;
        check("hold_second_accept", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        finish_rsp("hold_second", exp_rd, exp_err);

        // Reset during WAIT discards the pending store.
        issue("rst_sw_20", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
        $display("rst_sw_20: store aborted by reset");
        xact("lw_20_old", 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 32'd0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            bit [31:0] a;
            bit        we;
            bit [2:0]  f3;
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 64));
            else                            a = 32'($urandom_range(0, 63));
            xact($sformatf("rand_%0d", i), we, f3, a, $urandom, 1'b0, 32'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
